median_stream_extend: RTL and testbench

- Upstream feeder for the 3x3 median core.
- Accepts a raw row-major WIDTH*HEIGHT 8-bit pixel stream over a valid/ready handshake.
- Emits the extended (WIDTH+1)*(HEIGHT+1) stream the core requires by inserting one pad beat after each row and one pad row after the last row.
- Output drives the core's in_valid/pixel_in directly. The core has no backpressure, so this block never stalls its output.

---
 rtl/median_pkg.sv | 29 ++
 rtl/raster_counter_xy.sv | 49 ++++
 rtl/median_stream_extend.sv | 87 ++++++++
 tb/tb_median_stream_extend.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/median_pkg.sv
// Shared definitions for the median filter pipeline: pixel width,
// default frame geometry and sizing helpers.
package median_pkg;

  localparam int PIX_W      = 8;
  localparam int DEF_WIDTH  = 430;
  localparam int DEF_HEIGHT = 554;

  // Bits needed to hold values 0..value-1; never returns less than 1.
  function automatic int clog2(input int value);
    int result;
    int rem;
    result = 0;
    rem    = value - 1;
    while (rem > 0) begin
      result = result + 1;
      rem    = rem >> 1;
    end
    return (result < 1) ? 1 : result;
  endfunction

  // Beats per frame once one pad column and one pad row are appended.
  function automatic int ext_beats(input int width, input int height);
    return (width + 1) * (height + 1);
  endfunction

  localparam int EXT_BEATS = ext_beats(DEF_WIDTH, DEF_HEIGHT);

endpackage

// File: rtl/raster_counter_xy.sv
// Column/row raster position counter. Columns run 0..COL_LAST, rows
// 0..ROW_LAST; each advance steps one position in row-major order and the
// step out of (COL_LAST, ROW_LAST) wraps to the origin with a wrap pulse.
module raster_counter_xy
  import median_pkg::*;
#(
  parameter int COL_LAST = 4,
  parameter int ROW_LAST = 3,
  parameter int COL_W    = clog2(COL_LAST + 1),
  parameter int ROW_W    = clog2(ROW_LAST + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             advance,
  output logic [COL_W-1:0] col,
  output logic [ROW_W-1:0] row,
  output logic             col_at_end,
  output logic             row_at_end,
  output logic             wrap
);

  localparam logic [COL_W-1:0] COL_END = COL_W'(COL_LAST);
  localparam logic [ROW_W-1:0] ROW_END = ROW_W'(ROW_LAST);

  // End-of-line / end-of-frame flags and the wrap pulse on the final step.
  always_comb begin
    col_at_end = (col == COL_END);
    row_at_end = (row == ROW_END);
    wrap       = advance && col_at_end && row_at_end;
  end

  // Position register: step the column, roll into the next row at line end.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: registered state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    if (rst) begin
      col <= '0;
      row <= '0;
    end else if (advance) begin
      if (col_at_end) begin
        col <= '0;
        row <= row_at_end ? '0 : row + ROW_W'(1);
      end else begin
        col <= col + COL_W'(1);
      end
    end
  end

endmodule

// File: rtl/median_stream_extend.sv
// Feeder for the 3x3 median core. Turns a WIDTH x HEIGHT raster accepted
// over valid/ready into the (WIDTH+1) x (HEIGHT+1) stream the core needs:
// one pad beat after every row and a full pad row after the last row.
// The output side never stalls; pads repeat the last accepted pixel.
module median_stream_extend
  import median_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int HEIGHT = DEF_HEIGHT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_pixel,
  input  logic             s_sof,
  output logic             out_valid,
  output logic [PIX_W-1:0] pixel_out,
  output logic             frame_done,
  output logic             sync_err
);

  localparam int COL_W = clog2(WIDTH + 1);
  localparam int ROW_W = clog2(HEIGHT + 1);

  logic [COL_W-1:0] col;
  logic [ROW_W-1:0] row;
  logic             col_at_end;
  logic             row_at_end;
  logic             wrap;
  logic             accept;
  logic             pad;
  logic             advance;
  logic             at_origin;
  logic [PIX_W-1:0] hold;

  // Next-beat position in the extended raster.
  raster_counter_xy #(
    .COL_LAST (WIDTH),
    .ROW_LAST (HEIGHT),
    .COL_W    (COL_W),
    .ROW_W    (ROW_W)
  ) u_pos (
    .clk        (clk),
    .rst        (rst),
    .advance    (advance),
    .col        (col),
    .row        (row),
    .col_at_end (col_at_end),
    .row_at_end (row_at_end),
    .wrap       (wrap)
  );

  // Ready depends only on the registered position; pad positions issue a
  // beat every cycle, active positions only on a handshake.
  always_comb begin
    s_ready   = !col_at_end && !row_at_end;
    accept    = s_valid && s_ready;
    pad       = !s_ready;
    advance   = accept || pad;
    at_origin = (col == '0) && (row == '0);
  end

  // Output beat register, pad hold value, frame pulse and sticky sync error.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid  <= 1'b0;
      pixel_out  <= '0;
      hold       <= '0;
      frame_done <= 1'b0;
      sync_err   <= 1'b0;
    end else begin
      out_valid  <= advance;
      frame_done <= wrap;
      if (accept) begin
        pixel_out <= s_pixel;
        hold      <= s_pixel;
        if (s_sof && !at_origin) begin
          sync_err <= 1'b1;
        end
      end else if (pad) begin
        pixel_out <= hold;
      end
    end
  end

endmodule

// File: tb/tb_median_stream_extend.sv
// Bench for median_stream_extend at WIDTH=4, HEIGHT=3. The expected
// extended stream of each frame is built from its pixel list and queued
// when the frame is issued; a monitor pops one entry per output beat.
module tb_median_stream_extend;
  import median_pkg::*;

  localparam int W      = 4;
  localparam int H      = 3;
  localparam int N      = W * H;
  localparam int BEATS  = ext_beats(W, H);
  localparam int BUDGET = 400;

  typedef struct packed {
    logic [PIX_W-1:0] pix;
    logic             done;
  } beat_t;

  logic             clk = 1'b0;
  logic             rst;
  logic             s_valid;
  logic             s_ready;
  logic [PIX_W-1:0] s_pixel;
  logic             s_sof;
  logic             out_valid;
  logic [PIX_W-1:0] pixel_out;
  logic             frame_done;
  logic             sync_err;

  beat_t            exp_q[$];
  int               beat_cyc[$];
  logic [PIX_W-1:0] fpix[$];
  logic             ready_log[$];
  int               compared   = 0;
  int               mismatched = 0;
  int               cyc        = 0;
  int               done_count = 0;
  logic             exp_sync   = 1'b0;

  median_stream_extend #(.WIDTH(W), .HEIGHT(H)) dut (
    .clk        (clk),
    .rst        (rst),
    .s_valid    (s_valid),
    .s_ready    (s_ready),
    .s_pixel    (s_pixel),
    .s_sof      (s_sof),
    .out_valid  (out_valid),
    .pixel_out  (pixel_out),
    .frame_done (frame_done),
    .sync_err   (sync_err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Extended stream: each row followed by its last pixel repeated once,
  // then a pad row of W+1 copies of the frame's last pixel; frame_done on
  // the very last beat.
  task automatic push_expected();
    beat_t b;
    for (int r = 0; r < H; r++) begin
      for (int c = 0; c < W; c++) begin
        b.pix = fpix[r*W + c]; b.done = 1'b0; exp_q.push_back(b);
      end
      b.pix = fpix[r*W + W - 1]; b.done = 1'b0; exp_q.push_back(b);
    end
    for (int c = 0; c <= W; c++) begin
      b.pix = fpix[N-1]; b.done = (c == W); exp_q.push_back(b);
    end
  endtask

  task automatic fill_frame(input int base, input bit rnd);
    fpix.delete();
    for (int k = 0; k < N; k++) fpix.push_back(rnd ? PIX_W'($urandom_range(255)) : PIX_W'(base + k));
  endtask

  // Offer the frame in fpix. mode: 100 = always valid, -1 = toggle,
  // otherwise percentage of cycles with s_valid. s_sof is set on pixel
  // indices sof_a/sof_b and randomly on cycles that cannot handshake.
  // Called and returns at 1 time unit after a rising edge.
  task automatic run_frame(input int mode, input int sof_a, input int sof_b);
    int  i = 0;
    int  budget = 0;
    bit  hs;
    push_expected();
    while (i < N && budget < BUDGET) begin
      check("sync_err", sync_err, exp_sync);
      if (mode == 100)     s_valid = 1'b1;
      else if (mode == -1) s_valid = (budget % 2 == 0);
      else                 s_valid = ($urandom_range(99) < mode);
      s_pixel = fpix[i];
      hs = s_valid && s_ready;
      s_sof = hs ? (i == sof_a || i == sof_b) : 1'($urandom_range(1));
      #1;
      ready_log.push_back(s_ready);
      @(posedge clk); #1;
      if (hs) begin
        if (s_sof && i != 0) exp_sync = 1'b1;
        i++;
      end
      budget++;
    end
    if (i < N) check("drive_timeout_accepts", i, N);
    s_valid = 1'b0;
    s_sof   = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge clk); n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    @(posedge clk); #1;
  endtask

  // Scoreboard monitor, sampling on the falling edge.
  initial begin : monitor
    beat_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (out_valid) begin
          check("beat_expected", exp_q.size() != 0, 1);
          if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            check("pixel_out", pixel_out, e.pix);
            check("frame_done", frame_done, e.done);
          end
          beat_cyc.push_back(cyc);
          if (frame_done) done_count++;
        end else begin
          check("frame_done_idle", frame_done, 0);
        end
      end
    end
  end

  initial begin
    int n;
    rst = 1'b1; s_valid = 1'b0; s_pixel = '0; s_sof = 1'b0;
    #3;
    check("rst_out_valid", out_valid, 0);
    check("rst_pixel_out", pixel_out, 0);
    check("rst_frame_done", frame_done, 0);
    check("rst_sync_err", sync_err, 0);
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    check("ready_after_reset", s_ready, 1);

    // Continuous frame 1..12 with ready pattern over 21 cycles.
    fill_frame(1, 0);
    ready_log.delete(); beat_cyc.delete(); done_count = 0;
    run_frame(100, -1, -1);
    repeat (7) begin
      ready_log.push_back(s_ready);
      @(posedge clk); #1;
    end
    wait_drain();
    check("s1_ready_log_len", ready_log.size(), 21);
    for (int k = 1; k <= 21 && k <= ready_log.size(); k++)
      check($sformatf("s1_ready_c%0d", k), ready_log[k-1], (k > BEATS) ? 1 : !((k % (W+1)) == 0 || k > (W+1)*H));
    check("s1_beats", beat_cyc.size(), BEATS);
    check("s1_done_count", done_count, 1);
    if (beat_cyc.size() == BEATS) check("s1_no_gap", beat_cyc[BEATS-1] - beat_cyc[0], BEATS - 1);

    // Toggling s_valid.
    fill_frame(100, 0);
    beat_cyc.delete(); done_count = 0;
    run_frame(-1, -1, -1);
    wait_drain();
    check("s2_beats", beat_cyc.size(), BEATS);
    check("s2_done_count", done_count, 1);

    // Two frames back-to-back.
    beat_cyc.delete(); done_count = 0;
    fill_frame(1, 0);
    run_frame(100, -1, -1);
    fill_frame(21, 0);
    run_frame(100, -1, -1);
    wait_drain();
    check("s3_beats", beat_cyc.size(), 2 * BEATS);
    check("s3_done_count", done_count, 2);
    if (beat_cyc.size() == 2 * BEATS) begin
      check("s3_frame_seam", beat_cyc[BEATS] - beat_cyc[BEATS-1], 1);
      check("s3_no_gap", beat_cyc[2*BEATS-1] - beat_cyc[0], 2 * BEATS - 1);
    end

    // s_sof at origin (no effect) and at pixel 6 (sticky error).
    fill_frame(1, 0);
    beat_cyc.delete(); done_count = 0;
    run_frame(100, 0, 5);
    wait_drain();
    check("s4_sync_err_held", sync_err, 1);
    check("s4_beats", beat_cyc.size(), BEATS);

    // Reset during pad-row beat 17, then a clean frame.
    fill_frame(1, 0);
    beat_cyc.delete(); done_count = 0;
    run_frame(100, -1, -1);
    n = 0;
    while (beat_cyc.size() < 16 && n < 100) begin
      @(negedge clk); #1; n++;
    end
    check("s5_reached_beat16", beat_cyc.size(), 16);
    @(posedge clk); #2;
    check("s5_beat17_valid", out_valid, 1);
    rst = 1'b1;
    #1;
    check("s5_rst_out_valid", out_valid, 0);
    check("s5_rst_pixel_out", pixel_out, 0);
    check("s5_rst_frame_done", frame_done, 0);
    check("s5_rst_sync_err", sync_err, 0);
    exp_q.delete(); exp_sync = 1'b0;
    @(posedge clk); @(posedge clk); #1 rst = 1'b0;
    check("s5_ready_after_reset", s_ready, 1);
    beat_cyc.delete(); done_count = 0;
    run_frame(100, -1, -1);
    wait_drain();
    check("s5_beats", beat_cyc.size(), BEATS);
    check("s5_done_count", done_count, 1);

    // Random pixels and random valid density.
    beat_cyc.delete(); done_count = 0;
    for (int f = 0; f < 4; f++) begin
      fill_frame(0, 1);
      run_frame(int'($urandom_range(20, 90)), (f == 2) ? 0 : -1, -1);
    end
    wait_drain();
    check("rand_beats", beat_cyc.size(), 4 * BEATS);
    check("rand_done_count", done_count, 4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
